// File: rtl/axis_west_tx.sv
//==============================================================================
// Module      : axis_west_tx
// Description : AXI4-Stream slave to Darwin3 west-link transmitter using a
//               4-phase return-to-zero REQ/ACK handshake, one word in flight.
//               Optional macro TX_ACK_SYNC_EN adds a 2-flop ACK synchronizer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_west_tx #(
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     S_AXIS_TDATA,
   input  logic                  S_AXIS_TVALID,
   input  logic [DATA_W/8-1:0]   S_AXIS_TKEEP,
   input  logic                  S_AXIS_TLAST,
   input  logic                  TX_ACK_WEST,
   output logic                  S_AXIS_TREADY,
   output logic [DATA_W-1:0]     TX_DATA_WEST,
   output logic                  TX_REQ_WEST
);

   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_WAIT_ACK_HI = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK_LO = 2'd2;

   logic [1:0] r_state;
   logic       w_ack_s;
   logic       w_tready;
   logic       w_unused_sideband;

   // TKEEP and TLAST are accepted but carry no protocol meaning on the link.
   assign w_unused_sideband = ^{S_AXIS_TKEEP, S_AXIS_TLAST};

`ifdef TX_ACK_SYNC_EN
   logic r_ack_meta;
   logic r_ack_sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ack_meta <= 1'b0;
         r_ack_sync <= 1'b0;
      end else begin
         r_ack_meta <= TX_ACK_WEST;
         r_ack_sync <= r_ack_meta;
      end
   end

   assign w_ack_s = r_ack_sync;
`else
   assign w_ack_s = TX_ACK_WEST;
`endif

   // Hold off new words while the far end is still acknowledging a previous one.
   assign w_tready      = rst_n && (r_state == ST_IDLE) && !w_ack_s;
   assign S_AXIS_TREADY = w_tready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         TX_REQ_WEST  <= 1'b0;
         TX_DATA_WEST <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Data and REQ launch together so data is settled when REQ is seen.
               if (S_AXIS_TVALID && w_tready) begin
                  TX_DATA_WEST <= S_AXIS_TDATA;
                  TX_REQ_WEST  <= 1'b1;
                  r_state      <= ST_WAIT_ACK_HI;
               end
            end
            ST_WAIT_ACK_HI: begin
               if (w_ack_s) begin
                  TX_REQ_WEST <= 1'b0;
                  r_state     <= ST_WAIT_ACK_LO;
               end
            end
            ST_WAIT_ACK_LO: begin
               if (!w_ack_s) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               TX_REQ_WEST <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axis_west_tx.sv
//==============================================================================
// Module      : tb_axis_west_tx
// Description : Directed, table-driven bench for axis_west_tx with a 3-flop
//               REQ->ACK echo far end (timing follows TX_ACK_SYNC_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axis_west_tx;

   localparam int DATA_W = 16;
`ifdef TX_ACK_SYNC_EN
   localparam int PERIOD = 13;
   localparam int REQ_HI = 6;
`else
   localparam int PERIOD = 9;
   localparam int REQ_HI = 4;
`endif
   localparam int NV = 6;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [DATA_W-1:0]    tdata;
   logic                 tvalid;
   logic [DATA_W/8-1:0]  tkeep;
   logic                 tlast;
   logic                 ack;
   logic                 tready;
   logic [DATA_W-1:0]    tx_data;
   logic                 tx_req;

   logic echo_en = 1'b1;
   logic man_ack = 1'b0;
   logic e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;
   logic req_q = 1'b0;
   int   req_pulses = 0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   axis_west_tx #(.DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .S_AXIS_TDATA  (tdata),
      .S_AXIS_TVALID (tvalid),
      .S_AXIS_TKEEP  (tkeep),
      .S_AXIS_TLAST  (tlast),
      .TX_ACK_WEST   (ack),
      .S_AXIS_TREADY (tready),
      .TX_DATA_WEST  (tx_data),
      .TX_REQ_WEST   (tx_req)
   );

   always #5 clk = ~clk;

   // Far end: REQ echoed as ACK after three clk registers.
   always @(posedge clk) begin
      e1    <= tx_req;
      e2    <= e1;
      e3    <= e2;
      req_q <= tx_req;
      cyc   <= cyc + 1;
      if (tx_req && !req_q) req_pulses <= req_pulses + 1;
   end

   assign ack = echo_en ? e3 : man_ack;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        keepx;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic last, input logic keepx,
                       output int acc, output bit ok);
      tdata  = d;
      tvalid = 1'b1;
      tlast  = last;
      tkeep  = keepx ? 2'bxx : 2'b11;
      ok     = 1'b0;
      acc    = 0;
      for (int k = 0; k < 60; k++) begin
         if (tready) begin
            step();
            acc = cyc;
            ok  = 1'b1;
            break;
         end
         step();
      end
      tlast = 1'b0;
      tkeep = 2'b11;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (tready) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   initial begin
      int  acc, prev, c0, n;
      bit  ok, stable, rdy_lo, req_ok;

      vecs[0] = '{data: 16'h1111, last: 1'b0, keepx: 1'b0, exp: 16'h1111};
      vecs[1] = '{data: 16'h2222, last: 1'b1, keepx: 1'b0, exp: 16'h2222};
      vecs[2] = '{data: 16'h3333, last: 1'b0, keepx: 1'b0, exp: 16'h3333};
      vecs[3] = '{data: 16'h4444, last: 1'b1, keepx: 1'b1, exp: 16'h4444};
      vecs[4] = '{data: 16'h5555, last: 1'b0, keepx: 1'b0, exp: 16'h5555};
      vecs[5] = '{data: 16'h6666, last: 1'b1, keepx: 1'b0, exp: 16'h6666};

      tdata = '0; tvalid = 1'b0; tlast = 1'b0; tkeep = 2'b11;
      prev = 0;

      // Reset state
      rst_n = 1'b0;
      step(); step(); step();
      chk("rst_req", {31'd0, tx_req}, 32'd0);
      chk("rst_data", {16'd0, tx_data}, 32'd0);
      chk("rst_tready", {31'd0, tready}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_tready", {31'd0, tready}, 32'd1);

      // Continuous stream with echoing far end
      for (int i = 0; i < NV; i++) begin
         send(vecs[i].data, vecs[i].last, vecs[i].keepx, acc, ok);
         if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
         end else begin
            chk("beat_data", {16'd0, tx_data}, {16'd0, vecs[i].exp});
            chk("beat_req", {31'd0, tx_req}, 32'd1);
            chk("beat_no_x", {31'd0, $isunknown(tx_data) || $isunknown(tx_req)}, 32'd0);
            if (i > 0) chk("period", acc - prev, PERIOD);
            prev   = acc;
            n      = 0;
            stable = 1'b1;
            rdy_lo = 1'b1;
            while (tx_req && n < 200) begin
               if (tx_data !== vecs[i].exp) stable = 1'b0;
               if (tready) rdy_lo = 1'b0;
               n++;
               step();
            end
            chk("req_hi_cycles", n, REQ_HI);
            chk("data_stable_req", {31'd0, stable}, 32'd1);
            chk("tready_low_req", {31'd0, rdy_lo}, 32'd1);
            if (i == 0) chk("tready_after_req_fall", {31'd0, tready}, 32'd0);
         end
      end
      tvalid = 1'b0;
      chk("req_pulse_count", req_pulses, NV);

      // TVALID low in IDLE, then immediate acceptance
      wait_ready(ok);
      chk("idle_ready", {31'd0, ok}, 32'd1);
      req_ok = 1'b1;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (tx_req !== 1'b0) req_ok = 1'b0;
         if (tx_data !== 16'h6666) stable = 1'b0;
      end
      chk("idle_req_low", {31'd0, req_ok}, 32'd1);
      chk("idle_data_hold", {31'd0, stable}, 32'd1);
      c0 = cyc;
      send(16'h7777, 1'b0, 1'b0, acc, ok);
      tvalid = 1'b0;
      chk("idle_accept_latency", acc - c0, 32'd1);
      chk("idle_accept_data", {16'd0, tx_data}, 32'h7777);

      // Far end silent, then ACK held high
      wait_ready(ok);
      echo_en = 1'b0;
      man_ack = 1'b0;
      send(16'h8888, 1'b0, 1'b0, acc, ok);
      tvalid = 1'b0;
      req_ok = 1'b1; rdy_lo = 1'b1; stable = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (tx_req !== 1'b1) req_ok = 1'b0;
         if (tready) rdy_lo = 1'b0;
         if (tx_data !== 16'h8888) stable = 1'b0;
         step();
      end
      chk("stall_req_high", {31'd0, req_ok}, 32'd1);
      chk("stall_tready_low", {31'd0, rdy_lo}, 32'd1);
      chk("stall_data", {31'd0, stable}, 32'd1);
      man_ack = 1'b1;
      for (int k = 0; k < 5; k++) step();
      req_ok = 1'b1; rdy_lo = 1'b1; stable = 1'b1;
      for (int k = 0; k < 25; k++) begin
         if (tx_req !== 1'b0) req_ok = 1'b0;
         if (tready) rdy_lo = 1'b0;
         if (tx_data !== 16'h8888) stable = 1'b0;
         step();
      end
      chk("ackhi_req_low", {31'd0, req_ok}, 32'd1);
      chk("ackhi_tready_low", {31'd0, rdy_lo}, 32'd1);
      chk("ackhi_data", {31'd0, stable}, 32'd1);
      man_ack = 1'b0;
      wait_ready(ok);
      chk("ack_release_ready", {31'd0, ok}, 32'd1);

      // Reset pulse during WAIT_ACK_HI with ACK high
      send(16'h9999, 1'b0, 1'b0, acc, ok);
      tvalid = 1'b0;
      step();
      chk("pre_rst_req", {31'd0, tx_req}, 32'd1);
      man_ack = 1'b1;
      rst_n   = 1'b0;
      step();
      chk("midrst_req", {31'd0, tx_req}, 32'd0);
      chk("midrst_data", {16'd0, tx_data}, 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("midrst_tready_ackhi", {31'd0, tready}, 32'd0);
      chk("midrst_no_req", {31'd0, tx_req}, 32'd0);
      man_ack = 1'b0;
      wait_ready(ok);
      chk("midrst_ready_after_ack", {31'd0, ok}, 32'd1);
      echo_en = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
